// File: rtl/alu_exec_seq_if.sv
// Decoder/ALU-side bus of the execute sequencer: instruction handshake in, operand selects and strobes out.
// master = decoder + ALU environment, slave = sequencer.
interface alu_exec_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [3:0]  in_tgt1;
  logic [3:0]  in_tgt2;
  logic [7:0]  db_in;
  logic        ij_in;
  logic [3:0]  tgt1;
  logic [3:0]  tgt2;
  logic [17:0] alu_op;
  logic        ealu;
  logic        reg_we;
  logic [3:0]  reg_wsel;
  logic        r1_we;
  logic        flags_we;
  logic        pc_load;
  logic        done;
  logic        fault;

  modport master (
    output in_valid, in_op, in_tgt1, in_tgt2, db_in, ij_in,
    input  in_ready, tgt1, tgt2, alu_op, ealu, reg_we, reg_wsel,
           r1_we, flags_we, pc_load, done, fault
  );

  modport slave (
    input  in_valid, in_op, in_tgt1, in_tgt2, db_in, ij_in,
    output in_ready, tgt1, tgt2, alu_op, ealu, reg_we, reg_wsel,
           r1_we, flags_we, pc_load, done, fault
  );
endinterface

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute sequencer for the 8-bit ALU: IDLE -> SETUP -> EXEC(N) -> WB, or SETUP -> FLT.
// Operand selects are held from SETUP through WB/FLT; strobes are decoded from the state register.
module alu_exec_seq #(
  parameter int unsigned EXEC_CYCLES   = 1,
  parameter int unsigned MULDIV_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_exec_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_FLT   = 3'd4;

  logic [2:0] r_state;
  logic [4:0] r_op;
  logic [3:0] r_tgt1;
  logic [3:0] r_tgt2;
  logic [7:0] r_cnt;

  logic w_is_jump;
  logic w_is_bin;
  logic w_is_muldiv;
  logic w_bad;
  logic w_active;
  logic w_wb;

  assign w_is_jump   = (r_op >= 5'd14) && (r_op <= 5'd17);
  assign w_is_muldiv = (r_op == 5'd4) || (r_op == 5'd5);

  always_comb begin
    w_is_bin = 1'b0;
    case (r_op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd12, 5'd13: w_is_bin = 1'b1;
      default:                                                       w_is_bin = 1'b0;
    endcase
  end

  // Divide-by-zero is judged on the operand the ALU sees while SETUP drives tgt2.
  assign w_bad = (r_op > 5'd17)
              || (!w_is_jump && !$onehot(r_tgt1))
              || (w_is_bin && !$onehot(r_tgt2))
              || ((r_op == 5'd5) && (bus.db_in == 8'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_tgt1  <= '0;
      r_tgt2  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_op    <= bus.in_op;
            r_tgt1  <= bus.in_tgt1;
            r_tgt2  <= bus.in_tgt2;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_bad) begin
            r_state <= S_FLT;
          end else begin
            r_cnt   <= w_is_muldiv ? 8'(MULDIV_CYCLES) : 8'(EXEC_CYCLES);
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt <= 8'd1) begin
            r_state <= S_WB;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_WB, S_FLT: begin
          r_op    <= '0;
          r_tgt1  <= '0;
          r_tgt2  <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_active = (r_state == S_EXEC) || (r_state == S_WB);
  assign w_wb     = (r_state == S_WB);

  assign bus.in_ready = (r_state == S_IDLE);
  assign bus.tgt1     = r_tgt1;
  assign bus.tgt2     = r_tgt2;
  assign bus.alu_op   = w_active ? (18'd1 << r_op) : '0;
  assign bus.ealu     = w_active;
  assign bus.reg_we   = w_wb && !w_is_jump;
  assign bus.reg_wsel = (w_wb && !w_is_jump) ? r_tgt1 : '0;
  assign bus.r1_we    = w_wb && w_is_muldiv;
  assign bus.flags_we = w_wb && !w_is_jump;
  assign bus.pc_load  = w_wb && w_is_jump && bus.ij_in;
  assign bus.done     = w_wb || (r_state == S_FLT);
  assign bus.fault    = (r_state == S_FLT);

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: per-instruction cycle walk with hand-computed strobe expectations.
module tb_alu_exec_seq;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  alu_exec_seq_if bus ();

  alu_exec_seq #(
    .EXEC_CYCLES  (1),
    .MULDIV_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Walks one instruction from IDLE back to IDLE; e_* are the expected WB strobes.
  task automatic run(input string tag, input logic [4:0] op, input logic [3:0] t1,
                     input logic [3:0] t2, input logic [7:0] db, input logic ij,
                     input bit hold, input bit e_flt, input int e_n,
                     input logic e_rwe, input logic e_r1, input logic e_fwe, input logic e_pc);
    chk({tag, ":idle_rdy"}, bus.in_ready, 1);
    bus.in_op    = op;
    bus.in_tgt1  = t1;
    bus.in_tgt2  = t2;
    bus.db_in    = db;
    bus.ij_in    = ij;
    bus.in_valid = 1'b1;
    tick();
    if (!hold) bus.in_valid = 1'b0;
    chk({tag, ":setup_tgt1"}, bus.tgt1, t1);
    chk({tag, ":setup_tgt2"}, bus.tgt2, t2);
    chk({tag, ":setup_op"}, bus.alu_op, 0);
    chk({tag, ":setup_ealu"}, bus.ealu, 0);
    chk({tag, ":setup_rdy"}, bus.in_ready, 0);
    if (e_flt) begin
      tick();
      chk({tag, ":flt_done"}, bus.done, 1);
      chk({tag, ":flt_fault"}, bus.fault, 1);
      chk({tag, ":flt_wr"}, {bus.reg_we, bus.r1_we, bus.flags_we, bus.pc_load}, 0);
      chk({tag, ":flt_op"}, bus.alu_op, 0);
    end else begin
      for (int i = 0; i < e_n; i++) begin
        tick();
        chk({tag, ":exec_op"}, bus.alu_op, 18'd1 << op);
        chk({tag, ":exec_ealu"}, bus.ealu, 1);
        chk({tag, ":exec_done"}, bus.done, 0);
        chk({tag, ":exec_wr"}, {bus.reg_we, bus.r1_we, bus.flags_we, bus.pc_load}, 0);
        chk({tag, ":exec_rdy"}, bus.in_ready, 0);
        chk({tag, ":exec_tgt1"}, bus.tgt1, t1);
      end
      tick();
      chk({tag, ":wb_done"}, bus.done, 1);
      chk({tag, ":wb_fault"}, bus.fault, 0);
      chk({tag, ":wb_op"}, bus.alu_op, 18'd1 << op);
      chk({tag, ":wb_reg_we"}, bus.reg_we, e_rwe);
      chk({tag, ":wb_r1_we"}, bus.r1_we, e_r1);
      chk({tag, ":wb_flags_we"}, bus.flags_we, e_fwe);
      chk({tag, ":wb_pc_load"}, bus.pc_load, e_pc);
      chk({tag, ":wb_wsel"}, bus.reg_wsel, e_rwe ? t1 : 4'b0000);
      chk({tag, ":wb_rdy"}, bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk({tag, ":ret_rdy"}, bus.in_ready, 1);
    chk({tag, ":ret_tgt1"}, bus.tgt1, 0);
    chk({tag, ":ret_done"}, bus.done, 0);
    chk({tag, ":ret_op"}, bus.alu_op, 0);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_tgt1  = '0;
    bus.in_tgt2  = '0;
    bus.db_in    = '0;
    bus.ij_in    = 1'b0;
    tick();
    tick();
    chk("rst_rdy", bus.in_ready, 1);
    chk("rst_tgt", {bus.tgt1, bus.tgt2}, 0);
    chk("rst_op", bus.alu_op, 0);
    chk("rst_outs", {bus.ealu, bus.reg_we, bus.reg_wsel, bus.r1_we, bus.flags_we,
                     bus.pc_load, bus.done, bus.fault}, 0);
    rst = 1'b0;
    tick();

    //   tag        op     t1       t2       db     ij hold flt N  rwe r1 fwe pc
    run("add",      5'd0,  4'b0001, 4'b0010, 8'd5,  0, 0,   0,  1, 1,  0, 1,  0);
    run("mul",      5'd4,  4'b0100, 4'b1000, 8'd7,  0, 0,   0,  2, 1,  1, 1,  0);
    run("div0",     5'd5,  4'b0001, 4'b0010, 8'd0,  0, 0,   1,  0, 0,  0, 0,  0);
    run("div",      5'd5,  4'b0010, 4'b0100, 8'd3,  0, 0,   0,  2, 1,  1, 1,  0);
    run("je_t",     5'd17, 4'b0001, 4'b0000, 8'd1,  1, 0,   0,  1, 0,  0, 0,  1);
    run("je_n",     5'd17, 4'b0001, 4'b0000, 8'd1,  0, 0,   0,  1, 0,  0, 0,  0);
    run("jmp",      5'd14, 4'b0000, 4'b0000, 8'd1,  1, 0,   0,  1, 0,  0, 0,  1);
    run("op20",     5'd20, 4'b0001, 4'b0010, 8'd1,  0, 0,   1,  0, 0,  0, 0,  0);
    run("sub_t2",   5'd1,  4'b0001, 4'b0011, 8'd1,  0, 0,   1,  0, 0,  0, 0,  0);
    run("inc",      5'd6,  4'b0010, 4'b0000, 8'd0,  0, 0,   0,  1, 1,  0, 1,  0);
    run("inc_t1",   5'd6,  4'b0000, 4'b0000, 8'd1,  0, 0,   1,  0, 0,  0, 0,  0);
    run("shl_hold", 5'd8,  4'b1000, 4'b0001, 8'd2,  0, 1,   0,  1, 1,  0, 1,  0);
    run("or",       5'd13, 4'b0100, 4'b0001, 8'd9,  0, 0,   0,  1, 1,  0, 1,  0);

    // Reset in the first EXEC cycle of a MUL must abort with no retirement.
    bus.in_op    = 5'd4;
    bus.in_tgt1  = 4'b0001;
    bus.in_tgt2  = 4'b0010;
    bus.db_in    = 8'd4;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rstx_exec_op", bus.alu_op, 18'd1 << 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstx_rdy", bus.in_ready, 1);
    chk("rstx_outs", {bus.tgt1, bus.tgt2, bus.alu_op, bus.ealu, bus.reg_we, bus.r1_we,
                      bus.flags_we, bus.pc_load, bus.done, bus.fault}, 0);
    tick();
    chk("rstx_after", {bus.done, bus.fault, bus.r1_we, bus.reg_we}, 0);
    chk("rstx_idle", bus.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
